id_ex_operand_stage: RTL

ID/EX boundary stage directly downstream of the register file. It takes combinational rs1/rs2 read data and applies bypass from the EX/MEM result and the WB write port, which is the same port that feeds the register file. It detects load-use hazards and registers the resolved operands, rd, and control into the ID/EX pipeline register. It honours the global stall used by the register file and a branch/jump flush from EX.

---
 rtl/core_pkg.sv | 6 +
 rtl/operand_bypass.sv | 26 ++
 rtl/id_ex_operand_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared datapath widths and operand forwarding select encoding.
package core_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    typedef enum logic [1:0] {FWD_RF, FWD_MEM, FWD_WB, FWD_ZERO} fwd_sel_e;
endpackage

// File: rtl/operand_bypass.sv
// operand_bypass: resolves one source operand from x0, EX/MEM, WB or register file data.
module operand_bypass
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int AW   = core_pkg::REG_AW
) (
    input  logic [AW-1:0]   idx,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_fwd_en,
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    output logic [XLEN-1:0] data,
    output fwd_sel_e        sel
);
    // WB must be bypassed: the register file only commits it at the coming edge.
    assign sel  = (idx == '0) ? FWD_ZERO :
                  (mem_fwd_en && mem_rd_addr == idx) ? FWD_MEM :
                  (wb_en && wb_rd_addr == idx) ? FWD_WB : FWD_RF;
    assign data = (sel == FWD_MEM) ? mem_rd_data :
                  (sel == FWD_WB)  ? wb_rd_data  :
                  (sel == FWD_RF)  ? rf_data     : '0;
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with operand bypass and load-use bubble insertion.
// Optional OPFETCH_PERF_EN adds perf_bubble_cnt counting inserted load-use bubbles.
module id_ex_operand_stage
    import core_pkg::*;
#(
    parameter int XLEN = core_pkg::XLEN,
    parameter int NREG = 32,
    localparam int AW  = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1_addr,
    input  logic [AW-1:0]   id_rs2_addr,
    input  logic [AW-1:0]   id_rd_addr,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic            id_is_load,
    input  logic            id_reg_write,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic            mem_fwd_en,
    input  logic [AW-1:0]   mem_rd_addr,
    input  logic [XLEN-1:0] mem_rd_data,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd_addr,
    input  logic [XLEN-1:0] wb_rd_data,
    output logic            hazard_stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_rs1_data,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [AW-1:0]   ex_rd_addr,
    output logic            ex_is_load,
    output logic            ex_reg_write
`ifdef OPFETCH_PERF_EN
    ,
    output logic [31:0]     perf_bubble_cnt
`endif
);
    logic [XLEN-1:0] rs1_byp, rs2_byp, rs1_res, rs2_res;
    fwd_sel_e        rs1_sel, rs2_sel;

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_rs1 (
        .idx(id_rs1_addr), .rf_data(id_rs1_data),
        .mem_fwd_en(mem_fwd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_en(wb_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .data(rs1_byp), .sel(rs1_sel)
    );

    operand_bypass #(.XLEN(XLEN), .AW(AW)) u_rs2 (
        .idx(id_rs2_addr), .rf_data(id_rs2_data),
        .mem_fwd_en(mem_fwd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .wb_en(wb_en), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
        .data(rs2_byp), .sel(rs2_sel)
    );

    assign rs1_res = (rs1_sel == FWD_ZERO) ? '0 : rs1_byp;
    assign rs2_res = (rs2_sel == FWD_ZERO) ? '0 : rs2_byp;

    assign hazard_stall = ex_valid && ex_is_load && ex_rd_addr != '0 && id_valid && !flush &&
                          ((id_uses_rs1 && id_rs1_addr == ex_rd_addr) ||
                           (id_uses_rs2 && id_rs2_addr == ex_rd_addr));

    // Flush beats stall; a hazard bubble only lands when the pipe is advancing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rs1_data  <= '0;
            ex_rs2_data  <= '0;
            ex_rd_addr   <= '0;
            ex_is_load   <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (flush || (!stall && hazard_stall)) begin
            ex_valid     <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_reg_write <= 1'b0;
        end else if (!stall) begin
            ex_valid     <= id_valid;
            ex_rs1_data  <= rs1_res;
            ex_rs2_data  <= rs2_res;
            ex_rd_addr   <= id_rd_addr;
            ex_is_load   <= id_valid && id_is_load;
            ex_reg_write <= id_valid && id_reg_write;
        end
    end

`ifdef OPFETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perf_bubble_cnt <= '0;
        else if (hazard_stall && !stall)
            perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
`endif
endmodule
